scmp_bus_ctl: RTL and testbench

- Bus cycle controller between the SC/MP microcode sequencer and the external 8060-style bus.
- Accepts single-byte read/write requests from the microcode and arbitrates for the bus via the BREQ/ENIN/ENOUT chain.
- Generates ADS/RD/WR strobes with multiplexed address, supports HOLD wait-state extension, and returns read data with a one-cycle done pulse.

---
 rtl/scmp_bus_ctl.sv | 209 ++++++++++++++++++++
 tb/tb_scmp_bus_ctl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scmp_bus_ctl.sv
// SC/MP bus cycle controller.
// Takes single-byte read/write requests from the microcode sequencer, arbitrates
// for the 8060-style bus through the BREQ/ENIN/ENOUT daisy chain, runs the
// ADS -> RD/WR strobe sequence with HOLD wait-state extension and reports
// completion with a one-cycle done pulse (plus err on HOLD timeout).
module scmp_bus_ctl #(
    parameter int unsigned STROBE_CYCLES = 2,   // minimum RD/WR strobe width, 1..15
    parameter int unsigned HOLD_TIMEOUT  = 255  // max HOLD extension clocks, 1..255
) (
    input  logic        clk,
    input  logic        rst_n,

    // Microcode side
    input  logic        req_rd,
    input  logic        req_wr,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic        done,
    output logic        err,
    output logic        busy,

    // External bus side
    output logic [11:0] bus_addr,
    output logic [7:0]  bus_D_out,
    output logic        bus_D_oe,
    input  logic [7:0]  bus_D_in,
    output logic        bus_ADS_n,
    output logic        bus_RD_n,
    output logic        bus_WR_n,
    input  logic        bus_HOLD_n,
    input  logic        bus_ENIN,
    output logic        bus_ENOUT,
    output logic        bus_BREQ_out
);

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StAds,
        StStrb,
        StRel
    } state_e;

    // Counter values that mark the last programmed strobe clock and the
    // HOLD extension limit.
    localparam logic [3:0] StrbLast  = 4'(STROBE_CYCLES - 1);
    localparam logic [7:0] HoldLimit = 8'(HOLD_TIMEOUT);

    state_e      state_q,    state_d;
    logic [15:0] addr_q,     addr_d;
    logic [7:0]  wdata_q,    wdata_d;
    logic        is_rd_q,    is_rd_d;
    logic [3:0]  strb_cnt_q, strb_cnt_d;
    logic [7:0]  hold_cnt_q, hold_cnt_d;
    logic [7:0]  rdata_q,    rdata_d;
    logic        err_q,      err_d;
    logic        end_strobe;

    // Next-state logic: request capture, arbitration wait, strobe timing and HOLD.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        is_rd_d    = is_rd_q;
        strb_cnt_d = strb_cnt_q;
        hold_cnt_d = hold_cnt_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        end_strobe = 1'b0;

        case (state_q)
            StIdle: begin
                err_d = 1'b0;
                if (req_rd || req_wr) begin
                    // A simultaneous write request is dropped: read wins.
                    addr_d  = addr;
                    wdata_d = wdata;
                    is_rd_d = req_rd;
                    state_d = StReq;
                end
            end

            StReq: begin
                // Wait for the chain to grant us the bus, however long it takes.
                if (bus_ENIN) begin
                    state_d = StAds;
                end
            end

            StAds: begin
                strb_cnt_d = 4'd0;
                hold_cnt_d = 8'd0;
                state_d    = StStrb;
            end

            StStrb: begin
                if (strb_cnt_q != StrbLast) begin
                    // HOLD is not looked at until the programmed width is used up.
                    strb_cnt_d = strb_cnt_q + 4'd1;
                end else if (bus_HOLD_n) begin
                    end_strobe = 1'b1;
                end else if (hold_cnt_q == HoldLimit) begin
                    // Slave held too long: terminate anyway and flag it.
                    end_strobe = 1'b1;
                    err_d      = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end

                if (end_strobe) begin
                    state_d = StRel;
                    if (is_rd_q) begin
                        rdata_d = bus_D_in;
                    end
                end
            end

            StRel: begin
                err_d   = 1'b0;
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers; reset abandons any cycle in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            addr_q     <= 16'h0000;
            wdata_q    <= 8'h00;
            is_rd_q    <= 1'b0;
            strb_cnt_q <= 4'd0;
            hold_cnt_q <= 8'd0;
            rdata_q    <= 8'h00;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            is_rd_q    <= is_rd_d;
            strb_cnt_q <= strb_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    // Bus and status outputs decoded from the registered state only.
    always_comb begin
        bus_ADS_n    = 1'b1;
        bus_RD_n     = 1'b1;
        bus_WR_n     = 1'b1;
        bus_addr     = 12'h000;
        bus_D_out    = 8'h00;
        bus_D_oe     = 1'b0;
        bus_BREQ_out = 1'b1;
        bus_ENOUT    = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;

        case (state_q)
            StIdle: begin
                bus_BREQ_out = 1'b0;
                bus_ENOUT    = bus_ENIN;
                busy         = 1'b0;
            end

            StReq: begin
            end

            StAds: begin
                // Upper address nibble rides on the data bus during ADS.
                bus_ADS_n = 1'b0;
                bus_addr  = addr_q[11:0];
                bus_D_out = {4'b0000, addr_q[15:12]};
                bus_D_oe  = 1'b1;
            end

            StStrb: begin
                bus_addr = addr_q[11:0];
                if (is_rd_q) begin
                    bus_RD_n = 1'b0;
                end else begin
                    bus_WR_n  = 1'b0;
                    bus_D_out = wdata_q;
                    bus_D_oe  = 1'b1;
                end
            end

            StRel: begin
                done = 1'b1;
            end

            default: begin
                bus_BREQ_out = 1'b0;
                busy         = 1'b0;
            end
        endcase
    end

    assign rdata = rdata_q;
    assign err   = err_q;

endmodule

// File: tb/tb_scmp_bus_ctl.sv
// Self-checking bench for scmp_bus_ctl (STROBE_CYCLES=2, HOLD_TIMEOUT=4).
module tb_scmp_bus_ctl;

    logic        clk;
    logic        rst_n;
    logic        req_rd;
    logic        req_wr;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        done;
    logic        err;
    logic        busy;
    logic [11:0] bus_addr;
    logic [7:0]  bus_D_out;
    logic        bus_D_oe;
    logic [7:0]  bus_D_in;
    logic        bus_ADS_n;
    logic        bus_RD_n;
    logic        bus_WR_n;
    logic        bus_HOLD_n;
    logic        bus_ENIN;
    logic        bus_ENOUT;
    logic        bus_BREQ_out;

    int n_checks;
    int n_errors;

    scmp_bus_ctl #(
        .STROBE_CYCLES(2),
        .HOLD_TIMEOUT (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_rd      (req_rd),
        .req_wr      (req_wr),
        .addr        (addr),
        .wdata       (wdata),
        .rdata       (rdata),
        .done        (done),
        .err         (err),
        .busy        (busy),
        .bus_addr    (bus_addr),
        .bus_D_out   (bus_D_out),
        .bus_D_oe    (bus_D_oe),
        .bus_D_in    (bus_D_in),
        .bus_ADS_n   (bus_ADS_n),
        .bus_RD_n    (bus_RD_n),
        .bus_WR_n    (bus_WR_n),
        .bus_HOLD_n  (bus_HOLD_n),
        .bus_ENIN    (bus_ENIN),
        .bus_ENOUT   (bus_ENOUT),
        .bus_BREQ_out(bus_BREQ_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] a;
        logic [7:0]  wd;
        logic [7:0]  din;
        logic [11:0] exp_addr;
        logic [7:0]  exp_hi;
        logic        exp_is_rd;
        logic [7:0]  exp_rdata;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One uncontended, HOLD-free cycle, checked clock by clock.
    task automatic run_txn(input vec_t v);
        chk("idle_enout", 32'(bus_ENOUT), 32'(bus_ENIN));
        chk("idle_busy", 32'(busy), 32'd0);
        req_rd   = v.rd;
        req_wr   = v.wr;
        addr     = v.a;
        wdata    = v.wd;
        bus_D_in = v.din;
        tick();
        req_rd = 1'b0;
        req_wr = 1'b0;
        addr   = ~v.a;
        wdata  = ~v.wd;
        chk("req_busy", 32'(busy), 32'd1);
        chk("req_breq", 32'(bus_BREQ_out), 32'd1);
        chk("req_enout", 32'(bus_ENOUT), 32'd0);
        chk("req_ads", 32'(bus_ADS_n), 32'd1);
        tick();
        chk("ads_n", 32'(bus_ADS_n), 32'd0);
        chk("ads_addr", 32'(bus_addr), 32'(v.exp_addr));
        chk("ads_dout", 32'(bus_D_out), 32'(v.exp_hi));
        chk("ads_oe", 32'(bus_D_oe), 32'd1);
        chk("ads_strobes", 32'({bus_RD_n, bus_WR_n}), 32'b11);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("strb_ads", 32'(bus_ADS_n), 32'd1);
            chk("strb_rd", 32'(bus_RD_n), 32'(!v.exp_is_rd));
            chk("strb_wr", 32'(bus_WR_n), 32'(v.exp_is_rd));
            chk("strb_addr", 32'(bus_addr), 32'(v.exp_addr));
            chk("strb_oe", 32'(bus_D_oe), 32'(!v.exp_is_rd));
            if (!v.exp_is_rd) chk("strb_dout", 32'(bus_D_out), 32'(v.wd));
            chk("strb_done", 32'(done), 32'd0);
        end
        tick();
        chk("rel_done", 32'(done), 32'd1);
        chk("rel_err", 32'(err), 32'd0);
        chk("rel_rdata", 32'(rdata), 32'(v.exp_rdata));
        chk("rel_strobes", 32'({bus_ADS_n, bus_RD_n, bus_WR_n}), 32'b111);
        chk("rel_oe", 32'(bus_D_oe), 32'd0);
        chk("rel_breq", 32'(bus_BREQ_out), 32'd1);
        tick();
        chk("post_done", 32'(done), 32'd0);
        chk("post_busy", 32'(busy), 32'd0);
        chk("post_breq", 32'(bus_BREQ_out), 32'd0);
        chk("post_rdata", 32'(rdata), 32'(v.exp_rdata));
    endtask

    // Read with HOLD driven per strobe clock; returns strobe width, err and rdata at done.
    task automatic run_hold_read(input logic [15:0] a, input logic stuck,
                                 output int width, output logic e, output logic [7:0] rd);
        bit got_done;
        width    = 0;
        got_done = 1'b0;
        e        = 1'b0;
        rd       = 8'h00;
        req_rd   = 1'b1;
        addr     = a;
        tick();
        req_rd = 1'b0;
        for (int t = 0; t < 30 && !got_done; t++) begin
            tick();
            if (!bus_RD_n) begin
                width++;
                // Stuck: never release. Otherwise HOLD low on strobe clocks 1..4, released on 5.
                bus_HOLD_n = stuck ? 1'b0 : (width >= 5);
                bus_D_in   = 8'h40 + 8'(width);
            end
            if (done) begin
                got_done = 1'b1;
                e        = err;
                rd       = rdata;
            end
        end
        if (!got_done) begin
            n_checks++;
            n_errors++;
            $display("FAIL hold_done_timeout: got no done expected done within 30 clocks");
        end
        bus_HOLD_n = 1'b1;
        tick();
    endtask

    initial begin
        int          w;
        logic        e;
        logic [7:0]  r;

        n_checks = 0;
        n_errors = 0;

        //                rd    wr    addr      wdata  din    exp_addr exp_hi is_rd rdata
        vecs[0] = '{1'b1, 1'b0, 16'h05A3, 8'h00, 8'hC7, 12'h5A3, 8'h00, 1'b1, 8'hC7};
        vecs[1] = '{1'b0, 1'b1, 16'h1234, 8'h9E, 8'h00, 12'h234, 8'h01, 1'b0, 8'hC7};
        vecs[2] = '{1'b1, 1'b1, 16'h8F0E, 8'hAA, 8'h3C, 12'hF0E, 8'h08, 1'b1, 8'h3C};
        vecs[3] = '{1'b0, 1'b1, 16'hABCD, 8'h55, 8'hEE, 12'hBCD, 8'h0A, 1'b0, 8'h3C};
        vecs[4] = '{1'b1, 1'b0, 16'hFFFF, 8'h12, 8'h81, 12'hFFF, 8'h0F, 1'b1, 8'h81};

        rst_n      = 1'b0;
        req_rd     = 1'b0;
        req_wr     = 1'b0;
        addr       = 16'h0000;
        wdata      = 8'h00;
        bus_D_in   = 8'h00;
        bus_HOLD_n = 1'b1;
        bus_ENIN   = 1'b1;

        #12;
        chk("rst_strobes", 32'({bus_ADS_n, bus_RD_n, bus_WR_n}), 32'b111);
        chk("rst_oe", 32'(bus_D_oe), 32'd0);
        chk("rst_breq", 32'(bus_BREQ_out), 32'd0);
        chk("rst_status", 32'({done, err, busy}), 32'b000);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_addr", 32'(bus_addr), 32'd0);
        chk("rst_dout", 32'(bus_D_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Table-driven uncontended reads/writes, including read-wins-over-write.
        foreach (vecs[i]) run_txn(vecs[i]);

        // ENOUT passes ENIN through while idle.
        bus_ENIN = 1'b0;
        #1 chk("idle_enout_lo", 32'(bus_ENOUT), 32'd0);
        bus_ENIN = 1'b1;
        #1 chk("idle_enout_hi", 32'(bus_ENOUT), 32'd1);

        // Arbitration wait: ENIN low for 6 clocks after accept.
        bus_ENIN = 1'b0;
        bus_D_in = 8'h11;
        req_rd   = 1'b1;
        addr     = 16'h0042;
        tick();
        req_rd = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("wait_breq", 32'(bus_BREQ_out), 32'd1);
            chk("wait_enout", 32'(bus_ENOUT), 32'd0);
            chk("wait_ads", 32'(bus_ADS_n), 32'd1);
            tick();
        end
        bus_ENIN = 1'b1;
        tick();
        chk("grant_ads", 32'(bus_ADS_n), 32'd0);
        chk("grant_addr", 32'(bus_addr), 32'h042);
        bus_ENIN = 1'b0;
        tick();
        chk("noabort_rd", 32'(bus_RD_n), 32'd0);
        tick();
        tick();
        chk("wait_done", 32'(done), 32'd1);
        chk("wait_rdata", 32'(rdata), 32'h11);
        bus_ENIN = 1'b1;
        tick();

        // HOLD for 3 clocks from the last programmed strobe clock.
        run_hold_read(16'h0300, 1'b0, w, e, r);
        chk("hold_width", 32'(w), 32'd5);
        chk("hold_err", 32'(e), 32'd0);
        chk("hold_rdata", 32'(r), 32'h45);

        // HOLD stuck low: forced end after 2+4 clocks with err.
        run_hold_read(16'h0777, 1'b1, w, e, r);
        chk("tmo_width", 32'(w), 32'd6);
        chk("tmo_err", 32'(e), 32'd1);
        chk("tmo_rdata", 32'(r), 32'h46);
        chk("tmo_err_clr", 32'(err), 32'd0);
        run_txn('{1'b0, 1'b1, 16'h2468, 8'h5B, 8'h00, 12'h468, 8'h02, 1'b0, 8'h46});

        // Reset asserted in the middle of a write strobe.
        req_wr = 1'b1;
        addr   = 16'h0123;
        wdata  = 8'h77;
        tick();
        req_wr = 1'b0;
        tick();
        tick();
        chk("pre_rst_wr", 32'(bus_WR_n), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_strobes", 32'({bus_ADS_n, bus_RD_n, bus_WR_n}), 32'b111);
        chk("arst_breq", 32'(bus_BREQ_out), 32'd0);
        chk("arst_oe", 32'(bus_D_oe), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("arst_no_done", 32'(done), 32'd0);
        end
        chk("arst_rdata", 32'(rdata), 32'd0);
        run_txn('{1'b1, 1'b0, 16'h0ABC, 8'h00, 8'h5D, 12'hABC, 8'h00, 1'b1, 8'h5D});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
